sram_bank_ctrl: RTL and testbench

Parametrised multi-bank SRAM controller for the EC accelerator's local buffers. It accepts a valid/ready request stream and responds on a valid/ready stream, so upstream code never has to track SRAM read latency.
- Storage is split into NUM_BANKS equal-width slices, with a per-slice write mask.
- Read latency is configurable, and a credit-limited response FIFO absorbs downstream backpressure.
- Memory is auto-cleared after reset.
- Optional parity checking is available.

---
 rtl/sram_bank_ctrl_pkg.sv | 22 ++
 rtl/sram_slice.sv | 33 +++
 rtl/sram_bank_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_ctrl_pkg.sv
// Shared types and helpers for the multi-bank SRAM controller.
// The parity helpers are only used when SRAM_BANK_CTRL_PARITY_EN is defined.
package sram_bank_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam int unsigned PAR_MAX_W = 256;

    function automatic int unsigned calc_slice_w(input int unsigned data_w,
                                                 input int unsigned num_banks);
        return data_w / num_banks;
    endfunction

    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sram_slice.sv
// One bank slice: flop-array storage, synchronous write, registered read
// followed by RD_LAT-1 extra output pipeline stages.
module sram_slice #(
    parameter int unsigned DEPTH  = 100,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] pipe_q [RD_LAT];

    // Rows beyond DEPTH read as zero so out-of-range requests never alias.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        pipe_q[0] <= (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/sram_bank_ctrl.sv
// Multi-bank SRAM controller with post-reset clear, credit-limited FWFT response
// FIFO and optional per-slice parity (enable with SRAM_BANK_CTRL_PARITY_EN).
module sram_bank_ctrl
    import sram_bank_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 100,
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned RSP_FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W         = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic                 req_wr,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [NUM_BANKS-1:0] req_wmask,
    output logic                 rsp_val,
    input  logic                 rsp_rdy,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic                 init_done
);

    localparam int unsigned SLICE_W = calc_slice_w(DATA_W, NUM_BANKS);
`ifdef SRAM_BANK_CTRL_PARITY_EN
    localparam int unsigned MEM_W = SLICE_W + 1;
`else
    localparam int unsigned MEM_W = SLICE_W;
`endif
    localparam int unsigned OUT_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    state_e            state_q;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              init_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done = init_done_q;

    logic [OUT_W-1:0] out_q, out_d;
    logic             addr_ok, wr_fire, rd_fire, rsp_fire;

    assign req_rdy = (state_q == RUN) && (out_q < OUT_W'(RSP_FIFO_DEPTH));
    assign addr_ok = 32'(req_addr) < DEPTH;
    assign wr_fire = req_val && req_rdy && req_wr && addr_ok;
    assign rd_fire = req_val && req_rdy && !req_wr;

    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_err;

    assign wr_addr = (state_q == INIT) ? init_cnt_q : req_addr;

`ifdef SRAM_BANK_CTRL_PARITY_EN
    logic [NUM_BANKS-1:0] par_bad;
    assign pipe_err = |par_bad;
`else
    assign pipe_err = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_slice
        logic               we;
        logic [MEM_W-1:0]   wd;
        logic [MEM_W-1:0]   rd;
        logic [SLICE_W-1:0] wslice;

        assign wslice = req_wdata[b*SLICE_W +: SLICE_W];

        always_comb begin
            we = 1'b0;
            wd = '0;
            if (state_q == INIT) begin
                we = 1'b1;
            end else if (wr_fire && req_wmask[b]) begin
                we = 1'b1;
`ifdef SRAM_BANK_CTRL_PARITY_EN
                wd = {even_parity(PAR_MAX_W'(wslice)), wslice};
`else
                wd = wslice;
`endif
            end
        end

        sram_slice #(
            .DEPTH  (DEPTH),
            .WIDTH  (MEM_W),
            .RD_LAT (RD_LAT),
            .ADDR_W (ADDR_W)
        ) u_slice (
            .clk_i   (clk),
            .we_i    (we),
            .waddr_i (wr_addr),
            .wdata_i (wd),
            .raddr_i (req_addr),
            .rdata_o (rd)
        );

        assign pipe_data[b*SLICE_W +: SLICE_W] = rd[SLICE_W-1:0];
`ifdef SRAM_BANK_CTRL_PARITY_EN
        assign par_bad[b] = rd[SLICE_W] ^ even_parity(PAR_MAX_W'(rd[SLICE_W-1:0]));
`endif
    end

    // Valid tokens travel alongside the slice read pipelines.
    logic [RD_LAT-1:0] vld_q;
    logic              pipe_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_fire;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign pipe_vld = vld_q[RD_LAT-1];

    logic [DATA_W-1:0] fifo_data_q [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OUT_W-1:0]  cnt_q, cnt_d;
    logic              fifo_empty, push, pop;
    logic [DATA_W-1:0] head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Fall-through: with an empty FIFO the pipeline output is presented directly
    // and only lands in storage if the consumer does not take it this cycle.
    assign fifo_empty = (cnt_q == '0);
    assign push       = pipe_vld && !(fifo_empty && rsp_rdy);
    assign pop        = !fifo_empty && rsp_rdy;
    assign rsp_val    = !fifo_empty || pipe_vld;
    assign rsp_fire   = rsp_val && rsp_rdy;
    assign head_data  = fifo_empty ? pipe_data : fifo_data_q[rptr_q];
    assign rsp_data   = rsp_val ? head_data : '0;

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + OUT_W'(1);
            2'b01:   cnt_d = cnt_q - OUT_W'(1);
            default: ;
        endcase
        out_d = out_q;
        case ({rd_fire, rsp_fire})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= pipe_data;
        end
    end

`ifdef SRAM_BANK_CTRL_PARITY_EN
    logic fifo_err_q [RSP_FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_err_q[wptr_q] <= pipe_err;
        end
    end

    assign rsp_err = rsp_val && (fifo_empty ? pipe_err : fifo_err_q[rptr_q]);
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed scoreboard bench for sram_bank_ctrl (DEPTH=100, RD_LAT=3, FIFO depth 4).
// Define SRAM_BANK_CTRL_PARITY_EN to also exercise a corrupted parity bit.
module tb_sram_bank_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 100;
    localparam int unsigned NB     = 2;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned FD     = 4;
    localparam int unsigned AW     = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_val, req_rdy, req_wr;
    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] req_wdata, rsp_data;
    logic [NB-1:0]     req_wmask;
    logic              rsp_val, rsp_rdy, rsp_err, init_done;

    always #5 clk = ~clk;

    sram_bank_ctrl #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .NUM_BANKS      (NB),
        .RD_LAT         (RD_LAT),
        .RSP_FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_val   (rsp_val),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    int              vectors     = 0;
    int              miscompares = 0;
    int unsigned     cyc         = 0;
    bit              mon_en      = 1'b0;
    bit              par_bad9    = 1'b0;
    logic [31:0]     model [DEPTH];
    logic [32:0]     exp_q [$];
    int unsigned     pop_cyc [$];
    logic [32:0]     mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_val === 1'b1 && rsp_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_val), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(mon_e[31:0]));
                    check("rsp_err", 64'(rsp_err), 64'(mon_e[32]));
                    pop_cyc.push_back(cyc);
                end
            end else if (rsp_val === 1'b0) begin
                check("idle_data", 64'(rsp_data), 64'(0));
                check("idle_err", 64'(rsp_err), 64'(0));
            end
        end
    end

    // Book-keeping for a request the DUT has just accepted.
    task automatic accept(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [NB-1:0] m);
        logic [31:0] v;
        if (wr) begin
            if (a < DEPTH) begin
                v = model[a];
                if (m[0]) v[15:0]  = d[15:0];
                if (m[1]) v[31:16] = d[31:16];
                model[a] = v;
            end
        end else begin
            v = (a < DEPTH) ? model[a] : 32'h0;
            exp_q.push_back({(a == 7'd9) && par_bad9, v});
        end
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [NB-1:0] m);
        bit acc = 1'b0;
        int budget = 0;
        req_val = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
        while (!acc && budget < 50) begin
            @(negedge clk);
            if (req_rdy === 1'b1) begin
                acc = 1'b1;
                accept(wr, a, d, m);
            end
            @(posedge clk); #1;
            budget++;
        end
        req_val = 1'b0;
        if (!acc) check("req_accept", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          seen;
        int          n;
        int          acc_n;
        logic [31:0] v;

        rst = 1'b1; req_val = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_rsp_val", 64'(rsp_val), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));

        // Init sweep: cycles 0..99 busy, cycle 100 ready.
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            @(negedge clk);
            check("init_req_rdy", 64'(req_rdy), 64'(0));
            if (k == int'(DEPTH) - 1) check("init_done_early", 64'(init_done), 64'(0));
        end
        @(negedge clk);
        check("init_done", 64'(init_done), 64'(1));
        check("init_req_rdy_up", 64'(req_rdy), 64'(1));
        @(posedge clk); #1;

        drive(1'b0, 7'd7, '0, '0);
        drain();

        // Masked writes merge per slice.
        drive(1'b1, 7'd5, 32'hAABBCCDD, 2'b01);
        drive(1'b1, 7'd5, 32'h11223344, 2'b10);
        drive(1'b0, 7'd5, '0, '0);
        drain();
        check("mask_model", 64'(model[5]), 64'h1122CCDD);

        // Read latency with an empty FIFO.
        drive(1'b0, 7'd5, '0, '0);
        @(negedge clk); check("lat_t1", 64'(rsp_val), 64'(0));
        @(negedge clk); check("lat_t2", 64'(rsp_val), 64'(0));
        @(negedge clk); check("lat_t3", 64'(rsp_val), 64'(1));
        @(posedge clk); #1;
        drain();

        // Back-to-back reads give one response per cycle.
        for (int i = 0; i < 8; i++) drive(1'b1, 7'(40 + i), 32'hC0DE0000 + 32'(i * 7919), 2'b11);
        for (int i = 0; i < 8; i++) drive(1'b0, 7'(40 + i), '0, '0);
        drain();
        n = pop_cyc.size();
        check("b2b_span", 64'(pop_cyc[n-1] - pop_cyc[n-8]), 64'(7));

        // Backpressure: credits cap accepted reads at the FIFO depth.
        for (int i = 0; i < 6; i++) drive(1'b1, 7'(20 + i), 32'h5A000000 | 32'(i), 2'b11);
        rsp_rdy = 1'b0; acc_n = 0;
        req_val = 1'b1; req_wr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_addr = 7'(20 + acc_n);
            @(negedge clk);
            if (req_rdy === 1'b1) begin accept(1'b0, req_addr, '0, '0); acc_n++; end
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(acc_n), 64'(FD));
        req_addr = 7'(20 + acc_n);
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("bp_rdy_low", 64'(req_rdy), 64'(0));
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_addr = 7'(20 + acc_n);
            @(negedge clk);
            if (req_rdy === 1'b1) begin accept(1'b0, req_addr, '0, '0); acc_n++; end
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        check("bp_one_more", 64'(acc_n), 64'(FD + 1));
        rsp_rdy = 1'b1;
        drain();

        // Out-of-range address: writes dropped, reads return zero.
        drive(1'b1, 7'd100, 32'hFFFFFFFF, 2'b11);
        drive(1'b0, 7'd36, '0, '0);
        drive(1'b0, 7'd4, '0, '0);
        drive(1'b0, 7'd99, '0, '0);
        drive(1'b0, 7'd100, '0, '0);
        drain();

        // Parity corruption on row 9 (only with the parity build).
        drive(1'b1, 7'd9, 32'h12345678, 2'b11);
`ifdef SRAM_BANK_CTRL_PARITY_EN
        dut.g_slice[0].u_slice.mem_q[9][16] = ~dut.g_slice[0].u_slice.mem_q[9][16];
        par_bad9 = 1'b1;
`endif
        drive(1'b0, 7'd9, '0, '0);
        drain();
        par_bad9 = 1'b0;

        // Reset with three reads in flight.
        rsp_rdy = 1'b0;
        drive(1'b0, 7'd20, '0, '0);
        drive(1'b0, 7'd21, '0, '0);
        drive(1'b0, 7'd22, '0, '0);
        rst = 1'b1;
        exp_q.delete();
        clear_model();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_flight_rsp_val", 64'(rsp_val), 64'(0));
        check("rst_flight_init_done", 64'(init_done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_rdy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 130 && !seen; c++) begin
            @(negedge clk);
            if (init_done === 1'b1) seen = 1'b1;
        end
        check("reinit_done", 64'(seen), 64'(1));
        @(posedge clk); #1;
        drive(1'b0, 7'd20, '0, '0);
        drain();
        v = model[20];
        check("reinit_cleared_model", 64'(v), 64'(0));

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
